// File: rtl/ex_div_unit.sv
// Multi-cycle 32-bit restoring divider for MIPS DIV/DIVU.
// Returns {remainder, quotient} for the HI/LO write path after 33 cycles.
module ex_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        sign1, sign2, signed_q;

    logic        accept;
    logic        last_step;
    logic [32:0] rem_sh;
    logic [31:0] quo_sh;
    logic [32:0] trial;
    logic [31:0] op1_abs, op2_abs;
    logic [31:0] q_fix, r_fix;

    assign accept    = start_i & ~annul_i;
    assign last_step = (cnt == 6'd32);

    // Shift {rem, quo} left by one; the 33-bit shifted remainder feeds the trial subtract.
    assign rem_sh = {rem, quo[31]};
    assign quo_sh = {quo[30:0], 1'b0};
    assign trial  = rem_sh - {1'b0, dvs};

    assign op1_abs = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;

    // Magnitudes are used throughout, so |0x80000000| wraps back to itself and the
    // overflow case falls out as quotient 0x80000000, remainder 0.
    assign q_fix = (signed_q && (sign1 ^ sign2)) ? (32'd0 - quo) : quo;
    assign r_fix = (signed_q && sign1)           ? (32'd0 - rem) : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = (opdata2_i == 32'd0) ? S_DIVZERO : S_RUN;
            end
            S_DIVZERO: begin
                state_nxt = annul_i ? S_IDLE : S_DONE;
            end
            S_RUN: begin
                if (annul_i)        state_nxt = S_IDLE;
                else if (last_step) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (annul_i || !start_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 6'd0;
            quo      <= 32'd0;
            rem      <= 32'd0;
            dvs      <= 32'd0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            signed_q <= 1'b0;
            result_o <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && opdata2_i != 32'd0) begin
                        quo      <= op1_abs;
                        dvs      <= op2_abs;
                        sign1    <= opdata1_i[31];
                        sign2    <= opdata2_i[31];
                        signed_q <= signed_div_i;
                        rem      <= 32'd0;
                        cnt      <= 6'd0;
                    end
                end
                S_DIVZERO: begin
                    result_o <= 64'd0;
                end
                S_RUN: begin
                    if (annul_i) begin
                        result_o <= 64'd0;
                    end else if (last_step) begin
                        result_o <= {r_fix, q_fix};
                    end else begin
                        if (!trial[32]) begin
                            rem <= trial[31:0];
                            quo <= quo_sh | 32'd1;
                        end else begin
                            rem <= rem_sh[31:0];
                            quo <= quo_sh;
                        end
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DONE: begin
                    if (annul_i || !start_i) result_o <= 64'd0;
                end
                default: result_o <= 64'd0;
            endcase
        end
    end

    assign ready_o = (state == S_DONE);
    assign busy_o  = (state == S_DIVZERO) || (state == S_RUN);

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: driver pushes expected results, monitor pops on ready.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    ex_div_unit dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] res;
        int          rdy_cyc;
    } exp_t;

    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, which truncates toward zero and keeps the
    // 0x80000000 / -1 quotient representable before taking the low 32 bits.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sd, q, r;
        longint unsigned ua, ud, uq, ur;
        logic [63:0]     qv, rv;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            q  = sa / sd;
            r  = sa % sd;
            qv = q;
            rv = r;
        end else begin
            ua = {32'd0, a};
            ud = {32'd0, b};
            uq = ua / ud;
            ur = ua % ud;
            qv = uq;
            rv = ur;
        end
        return {rv[31:0], qv[31:0]};
    endfunction

    logic ready_q = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ready_o && !ready_q) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("ready_cycle", 64'(cyc), 64'(e.rdy_cyc));
            end
        end
        ready_q = ready_o;
    end

    // Called right after a falling edge; the next rising edge samples the start.
    task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit scramble);
        int          busy_n;
        int          n;
        int          lat;
        logic [63:0] r0;
        exp_t        e;
        busy_n = 0;
        n      = 0;
        lat    = (b == 32'd0) ? 1 : 33;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        e.res     = ref_div(s, a, b);
        e.rdy_cyc = cyc + 1 + lat;
        sb.push_back(e);
        do begin
            @(negedge clk);
            n++;
            if (busy_o) busy_n++;
            if (scramble && n == 2) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~s;
            end
        end while (!ready_o && n < 100);
        if (!ready_o) check("ready_timeout", 64'd0, 64'd1);
        check("busy_cycles", 64'(busy_n), 64'(lat));
        r0 = result_o;
        repeat (hold) begin
            @(negedge clk);
            check("done_hold_result", result_o, r0);
            check("done_hold_ready", {63'd0, ready_o}, 64'd1);
        end
        start_i = 1'b0;
        @(negedge clk);
        check("exit_ready", {63'd0, ready_o}, 64'd0);
        check("exit_result", result_o, 64'd0);
    endtask

    initial begin
        #1;
        check("reset_result", result_o, 64'd0);
        check("reset_flags", {62'd0, ready_o, busy_o}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        do_div(1'b0, 32'd5, 32'd0, 0, 1'b0);
        do_div(1'b1, 32'hFFFF_FC18, 32'd3, 5, 1'b1);

        // Annul part-way through the run, then restart at once.
        signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_mid_flags", {62'd0, ready_o, busy_o}, 64'd0);
        check("annul_mid_result", result_o, 64'd0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);

        // Annul coinciding with the final edge of the run discards the result.
        signed_div_i = 1'b0; opdata1_i = 32'd999; opdata2_i = 32'd10; start_i = 1'b1;
        repeat (33) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_last_flags", {62'd0, ready_o, busy_o}, 64'd0);
        check("annul_last_result", result_o, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        signed_div_i = 1'b1; opdata1_i = 32'd54321; opdata2_i = 32'd13; start_i = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_flags", {62'd0, ready_o, busy_o}, 64'd0);
        check("async_rst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_div(1'b1, 32'd54321, 32'd13, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            bit          s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case (i % 5)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'd0 - 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (i % 4 == 3) a = 32'h8000_0000;
            do_div(s, a, b, i % 3, 1'(i % 2));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
